// File: rtl/aximem_arbiter_if.sv
// ---------------------------------------------------------------------------
// aximem_arbiter_if
//
// Bundles every handshake and bus signal of the two-requester memory
// arbiter. Clock and reset are kept as plain module ports.
//
// Signals (directions as seen by the arbiter, i.e. the "slave" modport):
//   r0_* / r1_*  requester command in (req, we, wstrb, addr, wdata),
//                grant pulse, completion pulse, read data and error out
//   m_*          memory command out (req, we, wstrb, addr, wdata),
//                memory ack / completion / read data in
//   busy, owner  arbiter status out
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment driving requests and modelling the memory
// ---------------------------------------------------------------------------
interface aximem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // requester 0 (CPU data port)
    logic              r0_req;
    logic              r0_we;
    logic [STRB_W-1:0] r0_wstrb;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    // requester 1 (axi_master_wrapper path)
    logic              r1_req;
    logic              r1_we;
    logic [STRB_W-1:0] r1_wstrb;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    // shared memory port
    logic              m_req;
    logic              m_we;
    logic [STRB_W-1:0] m_wstrb;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    // status
    logic              busy;
    logic              owner;

    modport slave (
        input  r0_req, r0_we, r0_wstrb, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_wstrb, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output m_req, m_we, m_wstrb, m_addr, m_wdata,
        input  m_ack, m_rvalid, m_rdata,
        output busy, owner
    );

    modport master (
        output r0_req, r0_we, r0_wstrb, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_we, r1_wstrb, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  m_req, m_we, m_wstrb, m_addr, m_wdata,
        output m_ack, m_rvalid, m_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/aximem_arbiter.sv
// ---------------------------------------------------------------------------
// aximem_arbiter
//
// Shares one memory port between two requesters with at most one
// transaction outstanding. A command is latched on grant, presented on the
// memory port until accepted, and the completion is routed back to the
// requester that owns the transaction. Ties are broken round-robin and a
// response that never arrives is completed with an error after TIMEOUT
// cycles spent in ISSUE+WAIT (TIMEOUT = 0 disables this).
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - aximem_arbiter_if.slave: requester commands/responses,
//            memory command/response, busy and owner status
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module aximem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    aximem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    // Keep at least one counter bit so the design still elaborates when the
    // timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Requester inputs gathered into vectors indexed by requester number
    // -----------------------------------------------------------------------
    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0][STRB_W-1:0] wstrb_vec;
    logic [1:0][ADDR_W-1:0] addr_vec;
    logic [1:0][DATA_W-1:0] wdata_vec;

    assign req_vec   = {bus.r1_req,   bus.r0_req};
    assign we_vec    = {bus.r1_we,    bus.r0_we};
    assign wstrb_vec = {bus.r1_wstrb, bus.r0_wstrb};
    assign addr_vec  = {bus.r1_addr,  bus.r0_addr};
    assign wdata_vec = {bus.r1_wdata, bus.r0_wdata};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_q;
    logic                   last_owner_q;
    logic                   owner_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [1:0]             gnt_q;
    logic [1:0]             rvalid_q;
    logic [1:0]             err_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    logic                   m_req_q;
    logic                   m_we_q;
    logic [STRB_W-1:0]      m_wstrb_q;
    logic [ADDR_W-1:0]      m_addr_q;
    logic [DATA_W-1:0]      m_wdata_q;

    // -----------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on a tie the requester
    // that did not own the previous transaction wins.
    // -----------------------------------------------------------------------
    logic grant_idx_d;

    always_comb begin
        grant_idx_d = 1'b0;
        unique case (req_vec)
            2'b01:   grant_idx_d = 1'b0;
            2'b10:   grant_idx_d = 1'b1;
            2'b11:   grant_idx_d = ~last_owner_q;
            default: grant_idx_d = 1'b0;
        endcase
    end

    // Command selected for latching on grant
    logic              cmd_we_d;
    logic [STRB_W-1:0] cmd_wstrb_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_d;

    assign cmd_we_d    = we_vec[grant_idx_d];
    assign cmd_wstrb_d = wstrb_vec[grant_idx_d];
    assign cmd_addr_d  = addr_vec[grant_idx_d];
    assign cmd_wdata_d = wdata_vec[grant_idx_d];

    // -----------------------------------------------------------------------
    // Timeout counter. cnt_d is the value the counter takes at this edge;
    // the timeout fires on the edge where that value reaches TIMEOUT, so the
    // error completion appears exactly TIMEOUT cycles after entering ISSUE.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_hit;

    assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_LIMIT);

    // -----------------------------------------------------------------------
    // Main FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;     // requester 0 wins the first tie
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_wstrb_q    <= '0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            // Pulses and read data live for one cycle only.
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;

            unique case (state_q)
                ST_IDLE: begin
                    if (|req_vec) begin
                        owner_q            <= grant_idx_d;
                        gnt_q[grant_idx_d] <= 1'b1;
                        m_req_q            <= 1'b1;
                        m_we_q             <= cmd_we_d;
                        m_wstrb_q          <= cmd_wstrb_d;
                        m_addr_q           <= cmd_addr_d;
                        m_wdata_q          <= cmd_wdata_d;
                        cnt_q              <= '0;
                        busy_q             <= 1'b1;
                        state_q            <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // m_rvalid is meaningless before acceptance and is ignored.
                    cnt_q <= cnt_d;
                    if (timeout_hit) begin
                        m_req_q           <= 1'b0;
                        rvalid_q[owner_q] <= 1'b1;
                        err_q[owner_q]    <= 1'b1;
                        last_owner_q      <= owner_q;
                        busy_q            <= 1'b0;
                        state_q           <= ST_IDLE;
                    end else if (bus.m_ack) begin
                        m_req_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // A completion arriving on the timeout edge takes priority.
                    if (bus.m_rvalid) begin
                        rvalid_q[owner_q] <= 1'b1;
                        rdata_q[owner_q]  <= m_we_q ? '0 : bus.m_rdata;
                        last_owner_q      <= owner_q;
                        busy_q            <= 1'b0;
                        state_q           <= ST_IDLE;
                    end else if (timeout_hit) begin
                        rvalid_q[owner_q] <= 1'b1;
                        err_q[owner_q]    <= 1'b1;
                        last_owner_q      <= owner_q;
                        busy_q            <= 1'b0;
                        state_q           <= ST_IDLE;
                    end
                end

                default: begin
                    m_req_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.r0_gnt    = gnt_q[0];
    assign bus.r1_gnt    = gnt_q[1];
    assign bus.r0_rvalid = rvalid_q[0];
    assign bus.r1_rvalid = rvalid_q[1];
    assign bus.r0_err    = err_q[0];
    assign bus.r1_err    = err_q[1];
    assign bus.r0_rdata  = rdata_q[0];
    assign bus.r1_rdata  = rdata_q[1];

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_wstrb   = m_wstrb_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;

    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    // Only one requester can hold a grant or a completion at a time.
    assert property (@(posedge clk) disable iff (reset) !(gnt_q[0] && gnt_q[1]));
    assert property (@(posedge clk) disable iff (reset) !(rvalid_q[0] && rvalid_q[1]));
    // The memory command is only presented while in ISSUE.
    assert property (@(posedge clk) disable iff (reset) m_req_q |-> (state_q == ST_ISSUE));
    // A completion always coincides with the return to IDLE.
    assert property (@(posedge clk) disable iff (reset) (|rvalid_q) |-> !busy_q);
    // The command does not move while the memory has not accepted it.
    assert property (@(posedge clk) disable iff (reset)
        (m_req_q && !bus.m_ack) |=> ($stable(m_addr_q) && $stable(m_wdata_q) &&
                                     $stable(m_wstrb_q) && $stable(m_we_q)));

endmodule

// File: tb/tb_aximem_arbiter.sv
module tb_aximem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aximem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    aximem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   gnt_order[$];
    int   rv_cnt[2];
    int   last_rv_cyc[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model
    // ------------------------------------------------------------------
    logic [31:0] mem_arr [logic [31:0]];
    int ack_delay   = 0;
    int rsp_delay   = 0;
    bit respond     = 1'b1;
    bit stray_issue = 1'b0;
    bit stray_idle  = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return ~a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    initial begin : mem_proc
        int          phase;
        int          cnt;
        logic        we_l;
        logic [31:0] a_l;
        logic [31:0] wd_l;
        logic [3:0]  ws_l;
        phase = 0;
        cnt   = 0;
        we_l  = 1'b0;
        a_l   = '0;
        wd_l  = '0;
        ws_l  = '0;
        bus.m_ack    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            bus.m_ack    = 1'b0;
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = '0;
            if (reset) begin
                phase = 0;
            end else begin
                case (phase)
                    0: begin
                        if (bus.m_req) begin
                            we_l = bus.m_we;
                            a_l  = bus.m_addr;
                            wd_l = bus.m_wdata;
                            ws_l = bus.m_wstrb;
                            if (stray_issue) begin
                                bus.m_rvalid = 1'b1;
                                bus.m_rdata  = 32'hBAD0_BAD0;
                                stray_issue  = 1'b0;
                            end
                            if (ack_delay == 0) begin
                                bus.m_ack = 1'b1;
                                phase     = 2;
                                cnt       = rsp_delay;
                            end else begin
                                cnt   = ack_delay;
                                phase = 1;
                            end
                        end else if (stray_idle) begin
                            bus.m_rvalid = 1'b1;
                            bus.m_rdata  = 32'h0BAD_F00D;
                            stray_idle   = 1'b0;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.m_ack = 1'b1;
                            phase     = 2;
                            cnt       = rsp_delay;
                        end
                    end
                    default: begin
                        if (!respond) begin
                            phase = 0;
                        end else if (cnt == 0) begin
                            bus.m_rvalid = 1'b1;
                            if (we_l) mem_arr[a_l] = merge(mem_read(a_l), wd_l, ws_l);
                            else      bus.m_rdata  = mem_read(a_l);
                            phase = 0;
                        end else begin
                            cnt--;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion monitor: pops the scoreboard on every rvalid
    // ------------------------------------------------------------------
    initial begin : monitor
        logic [1:0]  rv;
        logic [1:0]  er;
        logic [31:0] rd [2];
        exp_t        e;
        forever begin
            @(posedge clk); #1;
            rv    = {bus.r1_rvalid, bus.r0_rvalid};
            er    = {bus.r1_err, bus.r0_err};
            rd[0] = bus.r0_rdata;
            rd[1] = bus.r1_rdata;
            for (int i = 0; i < 2; i++) begin
                if (rv[i]) begin
                    check_eq($sformatf("sb_nonempty_r%0d", i), 64'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq("rvalid_port", i, e.idx);
                        check_eq($sformatf("err_r%0d", i), er[i], e.err);
                        check_eq($sformatf("rdata_r%0d", i), rd[i], e.rdata);
                    end
                    rv_cnt[i]++;
                    last_rv_cyc[i] = cyc;
                    $display("txn r%0d done: err=%0d rdata=0x%08h cycle=%0d", i, er[i], rd[i], cyc);
                end else begin
                    check_eq($sformatf("idle_outputs_r%0d", i), {er[i], rd[i]}, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_cmd(input int idx, input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] ws);
        if (idx == 0) begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd; bus.r0_wstrb = ws;
        end else begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd; bus.r1_wstrb = ws;
        end
    endtask

    task automatic set_req(input int idx, input logic v);
        if (idx == 0) bus.r0_req = v;
        else          bus.r1_req = v;
    endtask

    // Raise a request, wait for its grant, push the expected completion.
    task automatic issue_req(input int idx, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] ws, input logic exp_err,
                             output int req_cyc, output int gnt_cyc);
        exp_t e;
        int   n;
        logic g;
        drive_cmd(idx, 1'b1, we, addr, wd, ws);
        req_cyc = cyc;
        n = 0;
        g = 1'b0;
        while (!g && n < 40) begin
            @(posedge clk); #1;
            g = (idx == 0) ? bus.r0_gnt : bus.r1_gnt;
            n++;
        end
        check_eq($sformatf("gnt_seen_r%0d", idx), g, 1);
        gnt_cyc = cyc;
        if (g) begin
            e.idx   = idx;
            e.err   = exp_err;
            e.rdata = (we || exp_err) ? 32'h0 : mem_read(addr);
            sb.push_back(e);
            gnt_order.push_back(idx);
            $display("txn r%0d granted: we=%0d addr=0x%08h cycle=%0d", idx, we, addr, cyc);
        end
        set_req(idx, 1'b0);
    endtask

    task automatic wait_rvalid(input int idx, output int at);
        int   n;
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < 40) begin
            @(posedge clk); #1;
            v = (idx == 0) ? bus.r0_rvalid : bus.r1_rvalid;
            n++;
        end
        check_eq($sformatf("rvalid_seen_r%0d", idx), v, 1);
        at = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.r0_err,
                                 bus.r1_err, bus.m_req, bus.m_we, bus.m_wstrb, bus.busy, bus.owner}, 0);
        check_eq({tag, "_maddr_wdata"}, {bus.m_addr, bus.m_wdata}, 0);
        check_eq({tag, "_rdata"}, {bus.r0_rdata, bus.r1_rdata}, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : main
        int rq0, rq1, g0, g1, t_rv, n, prev_g, rv1_before;
        drive_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        drive_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        mem_arr[32'h10] = 32'hDEAD_BEEF;
        rv_cnt[0] = 0; rv_cnt[1] = 0;
        last_rv_cyc[0] = 0; last_rv_cyc[1] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single read: gnt at +1, rvalid at +3
        issue_req(0, 1'b0, 32'h10, '0, '0, 1'b0, rq0, g0);
        check_eq("single_gnt_latency", g0 - rq0, 1);
        check_eq("single_mreq_at_gnt", {bus.m_req, bus.m_addr}, {1'b1, 32'h10});
        check_eq("single_busy_owner", {bus.busy, bus.owner, bus.r1_gnt}, 3'b100);
        wait_rvalid(0, t_rv);
        check_eq("single_rvalid_latency", t_rv - rq0, 3);
        drain();

        // Tie after reset: r0 first, r1 right after r0 completes
        do_reset("reset_before_tie");
        gnt_order.delete();
        fork
            issue_req(0, 1'b0, 32'h10, '0, '0, 1'b0, rq0, g0);
            issue_req(1, 1'b0, 32'h14, '0, '0, 1'b0, rq1, g1);
        join
        drain();
        check_eq("tie1_count", gnt_order.size(), 2);
        check_eq("tie1_first", gnt_order[0], 0);
        check_eq("tie1_second", gnt_order[1], 1);
        check_eq("tie1_r1_after_r0_done", g1, last_rv_cyc[0] + 1);

        // Second tie: last owner was r1, so r0 wins again
        gnt_order.delete();
        fork
            issue_req(0, 1'b0, 32'h18, '0, '0, 1'b0, rq0, g0);
            issue_req(1, 1'b0, 32'h1C, '0, '0, 1'b0, rq1, g1);
        join
        drain();
        check_eq("tie2_first", gnt_order[0], 0);
        check_eq("tie2_second", gnt_order[1], 1);

        // Write with strobe and delayed ack: command stable through ISSUE
        ack_delay = 4;
        issue_req(1, 1'b1, 32'h20, 32'hA5A5_A5A5, 4'b0011, 1'b0, rq1, g1);
        n = 0;
        while (bus.m_req && n < 12) begin
            check_eq("wr_m_addr", bus.m_addr, 32'h20);
            check_eq("wr_m_wdata", bus.m_wdata, 32'hA5A5_A5A5);
            check_eq("wr_m_wstrb_we", {bus.m_wstrb, bus.m_we}, {4'b0011, 1'b1});
            n++;
            @(posedge clk); #1;
        end
        check_eq("wr_issue_cycles", n, 5);
        drain();
        ack_delay = 0;
        check_eq("wr_merge", mem_read(32'h20), 32'hFFFF_A5A5);
        issue_req(0, 1'b0, 32'h20, '0, '0, 1'b0, rq0, g0);
        drain();

        // Back-to-back: r0 holds req, grants every 3rd cycle
        drive_cmd(0, 1'b1, 1'b0, 32'h10, '0, '0);
        prev_g = 0;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!bus.r0_gnt && n < 20);
            check_eq("b2b_gnt_seen", bus.r0_gnt, 1);
            e.idx = 0; e.err = 1'b0; e.rdata = mem_read(32'h10);
            sb.push_back(e);
            $display("txn r0 granted: we=0 addr=0x00000010 cycle=%0d", cyc);
            if (k > 0) check_eq("b2b_spacing", cyc - prev_g, 3);
            prev_g = cyc;
        end
        set_req(0, 1'b0);
        drain();

        // Stray m_rvalid during ISSUE is ignored
        ack_delay   = 2;
        stray_issue = 1'b1;
        issue_req(1, 1'b0, 32'h50, '0, '0, 1'b0, rq1, g1);
        drain();
        check_eq("stray_issue_consumed", stray_issue, 0);
        ack_delay = 0;

        // Timeout: memory never completes
        respond = 1'b0;
        issue_req(0, 1'b0, 32'h40, '0, '0, 1'b1, rq0, g0);
        wait_rvalid(0, t_rv);
        check_eq("timeout_latency", t_rv - g0, TIMEOUT);
        check_eq("timeout_busy_mreq", {bus.busy, bus.m_req}, 0);
        drain();
        respond = 1'b1;

        // Mid-transaction reset: no completion, stray response afterwards ignored
        rsp_delay  = 5;
        rv1_before = rv_cnt[1];
        drive_cmd(1, 1'b1, 1'b0, 32'h30, '0, '0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.r1_gnt && n < 20);
        check_eq("midrst_gnt", {bus.r1_gnt, bus.owner}, 2'b11);
        set_req(1, 1'b0);
        @(posedge clk); #1;
        check_eq("midrst_in_wait", {bus.busy, bus.m_req}, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        stray_idle = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("midrst_no_completion", rv_cnt[1] - rv1_before, 0);
        check_eq("midrst_idle", {bus.busy, 1'b0, stray_idle}, 0);
        check_eq("midrst_sb_empty", sb.size(), 0);
        rsp_delay = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
